multi_edge_sync: RTL
====================

# multi_edge_sync

Multi-channel synchronizer and edge-event catcher for asynchronous inputs such as keys, switches and externally clocked strobes. Each channel is synchronized into the `clk` domain through a parametrised flop chain, edge-detected per a compile-time mode, and latched into a sticky pending flag. The flag stays set until the consuming FSM acknowledges it, and a missed-event overflow flag is kept alongside. The block sits between board I/O and the control FSMs, generalising the single-channel pulse synchronizer.

## Interface
Parameters:
- `NUM_CH`, 4: number of independent channels (≥1).
- `SYNC_STAGES`, 2: synchronizer flops per channel (≥2).
- `EDGE_MODE`, `EDGE_RISE`: edge type that generates events; one of `EDGE_RISE`, `EDGE_FALL`, `EDGE_BOTH` (package enum).
- `DEBOUNCE_CYCLES`, 4: stable cycles required before a level change is accepted (≥1); used only when debounce is compiled in.

Ports:
- `clk`  in  1  sole clock; all state on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `async_in`  in  NUM_CH  raw asynchronous inputs.
- `sync_level`  out  NUM_CH  synchronized (and, if enabled, debounced) level.
- `edge_pulse`  out  NUM_CH  one-cycle pulse per accepted edge.
- `pending`  out  NUM_CH  sticky event flag.
- `ack`  in  NUM_CH  per-channel clear request, sampled on posedge.
- `overflow`  out  NUM_CH  sticky flag: an event arrived while `pending` was already set.
- `any_pending`  out  1  OR-reduction of `pending`.

## Operation
- **Reset:** all sync flops, `sync_level`, the previous-level register, `edge_pulse`, `pending`, `overflow` and the debounce counters go to 0. `any_pending` is 0.
- **Synchronizer:** `async_in[i]` passes through `SYNC_STAGES` flops. The last stage feeds `sync_level[i]` directly when debounce is compiled out.
- **Edge detect:** a registered copy `prev[i]` of `sync_level[i]` is kept.
  - rise event = `sync_level & ~prev`
  - fall event = `~sync_level & prev`
  - both = either
  - `edge_pulse[i]` is registered and high for exactly one cycle per event.
- **Input high through reset:** `prev` resets to 0, so an input held high at reset release produces one rise event.
- **Pending/ack, per channel, per cycle:**
  - event=1: `pending` ← 1; if `pending` was 1 and `ack`=0, then `overflow` ← 1.
  - event=1 and `ack`=1 in the same cycle: `pending` stays 1; `overflow` ← 0 (the new event replaces the acknowledged one).
  - event=0 and `ack`=1: `pending` ← 0 and `overflow` ← 0.
  - `ack` while `pending`=0 is a no-op.
- **Channel independence:** channels never interact except through `any_pending`.
- **Minimum pulse width:** inputs are level-sampled. Pulses narrower than one `clk` period may be missed; this is a documented restriction.

## Timing
- `async_in` change to `sync_level` change: `SYNC_STAGES` posedges after the first capturing edge, plus one capture-uncertainty cycle.
- `sync_level` change to `edge_pulse` and `pending` assertion: 1 cycle, with both asserting in the same cycle.
- `ack` to `pending` deassertion: visible the cycle after `ack` is sampled.
- `any_pending` is combinational from the `pending` registers.
- Reset assertion clears all outputs immediately, mid-operation included. Deassertion is expected synchronous to `clk` (upstream reset synchronizer).

## Configuration
- **With `MULTI_EDGE_SYNC_DEBOUNCE_EN` defined:** each channel inserts a debounce stage after the sync chain.
  - A counter of width `$clog2(DEBOUNCE_CYCLES+1)` increments while the last sync stage differs from `sync_level`, and resets to 0 when they match.
  - `sync_level` toggles, and the counter clears, when the count reaches `DEBOUNCE_CYCLES`.
  - This adds `DEBOUNCE_CYCLES` cycles of latency. Bounces shorter than that produce no event.
- **Without it:** no counter is generated, and `sync_level` equals the last sync stage.

## Structure
- **Package `multi_edge_sync_pkg`:**
  - `edge_mode_e` enum: `EDGE_RISE`=0, `EDGE_FALL`=1, `EDGE_BOTH`=2.
  - Constant `MIN_SYNC_STAGES`=2.
- **Sub-module `edge_sync_chan`:** one channel, holding the sync chain, optional debounce, edge detect and pending/overflow logic.
  - The top instantiates it `NUM_CH` times with a generate loop and builds `any_pending`.
- **Elaboration check:** `SYNC_STAGES` < `MIN_SYNC_STAGES` or `DEBOUNCE_CYCLES` < 1 is an elaboration error.

## Test plan
- **Reset mid-operation:** `NUM_CH`=4, `async_in`=4'b0000, raise ch0 → `sync_level[0]`=1 after 2–3 cycles, `edge_pulse[0]` high for exactly 1 cycle a cycle later, `pending[0]`=1, `any_pending`=1. Assert `reset_n`=0 mid-stream → all outputs 0 immediately.
- **Edge modes, falling:** `EDGE_MODE`=`EDGE_FALL`, toggle ch2 0→1→0 with 10-cycle holds → exactly one `edge_pulse[2]`, on the 1→0 transition. Repeat with `EDGE_BOTH` → two pulses.
- **Ack handshake:** set `pending[1]`, pulse `ack[1]` one cycle → `pending[1]`=0 next cycle. `ack[1]` with `pending[1]`=0 → no change.
- **Overflow and simultaneous ack:** two rise events on ch3 without ack → `overflow[3]`=1, `pending[3]`=1. Third event in the same cycle as `ack[3]` → `pending[3]`=1, `overflow[3]`=0.
- **Debounce bounce rejection:** with `MULTI_EDGE_SYNC_DEBOUNCE_EN`, `DEBOUNCE_CYCLES`=4, glitch ch0 high for 3 cycles → no event. Hold high for 8 cycles → one event, `sync_level` rises 4 cycles after the sync-chain output.
- **Independence:** random `async_in` on all 4 channels for 10k cycles versus a scoreboard model → per-channel event count and pending/overflow flags match exactly.

Source files
------------

// File: rtl/multi_edge_sync_pkg.sv
// Shared types and limits for the multi-channel
// synchronizer / edge-event catcher.
package multi_edge_sync_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/edge_sync_chan.sv
// One channel: sync chain, optional debounce
// (MULTI_EDGE_SYNC_DEBOUNCE_EN), edge detect, sticky pending/overflow.
// Ports: clk, reset_n, async_in, ack -> sync_level,
// edge_pulse, pending, overflow.
module edge_sync_chan
  import multi_edge_sync_pkg::*;
#(
  parameter int         SYNC_STAGES     = 2,
  parameter edge_mode_e EDGE_MODE       = EDGE_RISE,
  parameter int         DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  input  logic ack,
  output logic sync_level,
  output logic edge_pulse,
  output logic pending,
  output logic overflow
);

  if (SYNC_STAGES < MIN_SYNC_STAGES ||
      DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("edge_sync_chan: bad SYNC_STAGES/DEBOUNCE_CYCLES");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_last;
  logic                   prev;
  logic                   event_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

`ifdef MULTI_EDGE_SYNC_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] db_cnt;
  logic [CW-1:0] db_nxt;
  logic          db_level;

  assign db_nxt = db_cnt + CW'(1);

  // Level flips only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (sync_last == db_level) begin
      db_cnt <= '0;
    end else if (db_nxt == DB_MAX) begin
      db_cnt   <= '0;
      db_level <= ~db_level;
    end else begin
      db_cnt <= db_nxt;
    end
  end

  assign sync_level = db_level;
`else
  assign sync_level = sync_last;
`endif

  always_comb begin
    event_hit = 1'b0;
    case (EDGE_MODE)
      EDGE_RISE: event_hit = sync_level & ~prev;
      EDGE_FALL: event_hit = ~sync_level & prev;
      EDGE_BOTH: event_hit = sync_level ^ prev;
      default:   event_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev       <= 1'b0;
      edge_pulse <= 1'b0;
      pending    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      prev       <= sync_level;
      edge_pulse <= event_hit;
      if (event_hit) begin
        pending <= 1'b1;
        // A fresh event replaces an acknowledged one.
        if (ack) begin
          overflow <= 1'b0;
        end else if (pending) begin
          overflow <= 1'b1;
        end
      end else if (ack) begin
        pending  <= 1'b0;
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_edge_sync.sv
// NUM_CH independent edge_sync_chan channels plus any_pending.
// Debounce is built in with MULTI_EDGE_SYNC_DEBOUNCE_EN defined.
// Ports: clk, reset_n, async_in, ack -> sync_level,
// edge_pulse, pending, overflow, any_pending.
module multi_edge_sync
  import multi_edge_sync_pkg::*;
#(
  parameter int         NUM_CH          = 4,
  parameter int         SYNC_STAGES     = 2,
  parameter edge_mode_e EDGE_MODE       = EDGE_RISE,
  parameter int         DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] async_in,
  output logic [NUM_CH-1:0] sync_level,
  output logic [NUM_CH-1:0] edge_pulse,
  output logic [NUM_CH-1:0] pending,
  input  logic [NUM_CH-1:0] ack,
  output logic [NUM_CH-1:0] overflow,
  output logic              any_pending
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_sync_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .EDGE_MODE       (EDGE_MODE),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .async_in   (async_in[i]),
      .ack        (ack[i]),
      .sync_level (sync_level[i]),
      .edge_pulse (edge_pulse[i]),
      .pending    (pending[i]),
      .overflow   (overflow[i])
    );
  end

  assign any_pending = |pending;

endmodule
